// File: rtl/sram_arb_pkg.sv
// Shared types, widths and defaults for the two-port SRAM controller arbiter.
package sram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned SRAM_CMD_W         = 8;
  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned STRB_W             = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam logic [31:0] ERR_RDATA_DEF      = 32'hDEAD_BEEF;

  // Round-robin choice: on a tie the port not served last wins.
  function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last);
    logic pick;
    if (pend0 && pend1) begin
      pick = ~last;
    end else if (pend1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// start/busy/done command channel; master issues commands, slave executes them.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic                  start;
  logic [SRAM_CMD_W-1:0] cmd;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     rdata;

  modport master (output start, cmd, addr, wdata, wstrb, input busy, done, rdata);
  modport slave  (input start, cmd, addr, wdata, wstrb, output busy, done, rdata);

endinterface

// File: rtl/sram_arb_port.sv
// Per-port request capture, pending flag, protocol-error detect and result/done return.
module sram_arb_port import sram_arb_pkg::*; (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [SRAM_CMD_W-1:0] cmd,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  cpl,
  input  logic [DATA_W-1:0]     cpl_rdata,
  output logic                  pending,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic [SRAM_CMD_W-1:0] cap_cmd,
  output logic [ADDR_W-1:0]     cap_addr,
  output logic [DATA_W-1:0]     cap_wdata,
  output logic [STRB_W-1:0]     cap_wstrb,
  output logic                  proto_hit
);

  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [SRAM_CMD_W-1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;

  // Completion only happens while pending, so a start in that cycle is a protocol error.
  always_comb begin
    pending_d = pending_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (cpl) begin
      pending_d = 1'b0;
      done_d    = 1'b1;
      rdata_d   = cpl_rdata;
    end else if (start && !pending_q) begin
      pending_d = 1'b1;
      cmd_d     = cmd;
      addr_d    = addr;
      wdata_d   = wdata;
      wstrb_d   = wstrb;
    end else begin
      pending_d = pending_q;
    end
  end

  // Port state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      pending_q <= pending_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign pending   = pending_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign cap_cmd   = cmd_q;
  assign cap_addr  = addr_q;
  assign cap_wdata = wdata_q;
  assign cap_wstrb = wstrb_q;
  assign proto_hit = start && pending_q;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM adapter between two start/busy/done masters.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  sram_arbiter_if.slave  p0,
  sram_arbiter_if.slave  p1,
  sram_arbiter_if.master sram,
  output logic           timeout_err,
  output logic           proto_err
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic [SRAM_CMD_W-1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  timeout_q, timeout_d;
  logic                  proto_q, proto_d;

  logic                  pend0_s, pend1_s, proto0_s, proto1_s, pick_s, cpl_s;
  logic [DATA_W-1:0]     result_s;
  logic [SRAM_CMD_W-1:0] cmd0_s, cmd1_s;
  logic [ADDR_W-1:0]     addr0_s, addr1_s;
  logic [DATA_W-1:0]     wdata0_s, wdata1_s;
  logic [STRB_W-1:0]     wstrb0_s, wstrb1_s;

  sram_arb_port u_port0 (
    .clk, .resetn,
    .start(p0.start), .cmd(p0.cmd), .addr(p0.addr), .wdata(p0.wdata), .wstrb(p0.wstrb),
    .cpl(cpl_s && !grant_q), .cpl_rdata(result_s),
    .pending(pend0_s), .done(p0.done), .rdata(p0.rdata),
    .cap_cmd(cmd0_s), .cap_addr(addr0_s), .cap_wdata(wdata0_s), .cap_wstrb(wstrb0_s),
    .proto_hit(proto0_s)
  );

  sram_arb_port u_port1 (
    .clk, .resetn,
    .start(p1.start), .cmd(p1.cmd), .addr(p1.addr), .wdata(p1.wdata), .wstrb(p1.wstrb),
    .cpl(cpl_s && grant_q), .cpl_rdata(result_s),
    .pending(pend1_s), .done(p1.done), .rdata(p1.rdata),
    .cap_cmd(cmd1_s), .cap_addr(addr1_s), .cap_wdata(wdata1_s), .cap_wstrb(wstrb1_s),
    .proto_hit(proto1_s)
  );

  assign pick_s = rr_pick(pend0_s, pend1_s, last_q);

  // Grant/complete FSM; a timed-out op also counts as served for fairness.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    timeout_d = timeout_q;
    proto_d   = proto_q || proto0_s || proto1_s;
    cpl_s     = 1'b0;
    result_s  = '0;
    case (state_q)
      IDLE: begin
        if (!sram.busy && (pend0_s || pend1_s)) begin
          grant_d = pick_s;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
          cmd_d   = pick_s ? cmd1_s   : cmd0_s;
          addr_d  = pick_s ? addr1_s  : addr0_s;
          wdata_d = pick_s ? wdata1_s : wdata0_s;
          wstrb_d = pick_s ? wstrb1_s : wstrb0_s;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (sram.done) begin
          cpl_s    = 1'b1;
          result_s = sram.rdata;
          last_d   = grant_q;
          state_d  = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          cpl_s     = 1'b1;
          result_s  = ERR_RDATA;
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers; port 1 counts as last served out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      timeout_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      timeout_q <= timeout_d;
      proto_q   <= proto_d;
    end
  end

  assign p0.busy     = pend0_s;
  assign p1.busy     = pend1_s;
  assign sram.start  = start_q;
  assign sram.cmd    = cmd_q;
  assign sram.addr   = addr_q;
  assign sram.wdata  = wdata_q;
  assign sram.wstrb  = wstrb_q;
  assign timeout_err = timeout_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a latency-programmable SRAM adapter model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic timeout_err, proto_err;

  sram_arbiter_if p0_if ();
  sram_arbiter_if p1_if ();
  sram_arbiter_if sram_if ();

  sram_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn), .p0(p0_if), .p1(p1_if), .sram(sram_if),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sreq_t;

  sreq_t       exp_sram_q[$];
  logic [31:0] exp_rd0_q[$];
  logic [31:0] exp_rd1_q[$];
  sreq_t       mon_e;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h1234_5678;
    return a ^ 32'hC3C3_0000;
  endfunction

  // Adapter model: done ad_lat cycles after start, busy in between.
  int          ad_lat = 5;
  int          ad_cnt = 0;
  logic        ad_active = 1'b0;
  logic [31:0] ad_addr = 32'h0;
  initial begin
    sram_if.busy  = 1'b0;
    sram_if.done  = 1'b0;
    sram_if.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sram_if.busy = 1'b0;
        sram_if.done = 1'b0;
        ad_active    = 1'b0;
      end else begin
        sram_if.done = 1'b0;
        if (ad_active) begin
          ad_cnt--;
          if (ad_cnt == 0) begin
            sram_if.done  = 1'b1;
            sram_if.rdata = mem_fn(ad_addr);
            sram_if.busy  = 1'b0;
            ad_active     = 1'b0;
          end
        end
        if (sram_if.start) begin
          ad_active    = 1'b1;
          ad_cnt       = ad_lat;
          ad_addr      = sram_if.addr;
          sram_if.busy = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: pops expectations as the DUT produces starts and dones.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (sram_if.start) begin
          if (exp_sram_q.size() == 0) begin
            check_eq("sram_unexp", 32'd1, 32'd0);
          end else begin
            mon_e = exp_sram_q.pop_front();
            check_eq("sram_cmd", {24'd0, sram_if.cmd}, {24'd0, mon_e.cmd});
            check_eq("sram_addr", sram_if.addr, mon_e.addr);
            check_eq("sram_wdata", sram_if.wdata, mon_e.wdata);
            check_eq("sram_wstrb", {28'd0, sram_if.wstrb}, {28'd0, mon_e.wstrb});
          end
        end
        if (p0_if.done) begin
          if (exp_rd0_q.size() == 0) check_eq("p0_done_unexp", 32'd1, 32'd0);
          else check_eq("p0_rdata", p0_if.rdata, exp_rd0_q.pop_front());
        end
        if (p1_if.done) begin
          if (exp_rd1_q.size() == 0) check_eq("p1_done_unexp", 32'd1, 32'd0);
          else check_eq("p1_rdata", p1_if.rdata, exp_rd1_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic [7:0] cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (port == 0) begin
      p0_if.start = 1'b1; p0_if.cmd = cmd; p0_if.addr = addr; p0_if.wdata = wdata; p0_if.wstrb = wstrb;
    end else begin
      p1_if.start = 1'b1; p1_if.cmd = cmd; p1_if.addr = addr; p1_if.wdata = wdata; p1_if.wstrb = wstrb;
    end
  endtask

  task automatic release_starts();
    p0_if.start = 1'b0;
    p1_if.start = 1'b0;
  endtask

  // Counts negedges until the selected event (0 sram_start, 1 p0_done, 2 p1_done, 3 sram_done).
  task automatic wait_evt(input int sel, input string tag, input int exp);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      case (sel)
        0: seen = sram_if.start;
        1: seen = p0_if.done;
        2: seen = p1_if.done;
        default: seen = sram_if.done;
      endcase
    end
    if (!seen) n = 999;
    check_eq(tag, n, exp);
  endtask

  task automatic push_op(input int port, input logic [7:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rd);
    exp_sram_q.push_back('{cmd: cmd, addr: addr, wdata: wdata, wstrb: wstrb});
    if (port == 0) exp_rd0_q.push_back(rd);
    else exp_rd1_q.push_back(rd);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {25'd0, p0_if.busy, p0_if.done, p1_if.busy, p1_if.done,
             sram_if.start, timeout_err, proto_err}, 32'd0);
    check_eq({tag, "_p0_rdata"}, p0_if.rdata, 32'd0);
    check_eq({tag, "_p1_rdata"}, p1_if.rdata, 32'd0);
    check_eq({tag, "_sram_addr"}, sram_if.addr, 32'd0);
    check_eq({tag, "_sram_wdata"}, sram_if.wdata, 32'd0);
    check_eq({tag, "_sram_cw"}, {20'd0, sram_if.cmd, sram_if.wstrb}, 32'd0);
  endtask

  initial begin
    p0_if.start = 1'b0; p0_if.cmd = 8'h00; p0_if.addr = 32'h0; p0_if.wdata = 32'h0; p0_if.wstrb = 4'h0;
    p1_if.start = 1'b0; p1_if.cmd = 8'h00; p1_if.addr = 32'h0; p1_if.wdata = 32'h0; p1_if.wstrb = 4'h0;
    repeat (3) step();
    check_all_zero("rst");
    resetn = 1'b1;
    step();
    check_all_zero("rst_rel");

    // Contention straight out of reset: port 0 wins.
    ad_lat = 4;
    push_op(0, 8'h01, 32'h0000_0400, 32'h1111_0000, 4'h0, mem_fn(32'h0000_0400));
    push_op(1, 8'h01, 32'h0000_0800, 32'h2222_0000, 4'h0, mem_fn(32'h0000_0800));
    drive(0, 8'h01, 32'h0000_0400, 32'h1111_0000, 4'h0);
    drive(1, 8'h01, 32'h0000_0800, 32'h2222_0000, 4'h0);
    step();
    release_starts();
    check_eq("A_busy", {30'd0, p0_if.busy, p1_if.busy}, 32'd3);
    wait_evt(0, "A_start0", 2);
    wait_evt(1, "A_done0", 5);
    check_eq("A_p1_rd_hold", p1_if.rdata, 32'd0);
    wait_evt(0, "A_start1", 1);
    wait_evt(2, "A_done1", 5);

    // Single read, 5-cycle adapter latency.
    step();
    ad_lat = 5;
    push_op(0, 8'h01, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678);
    drive(0, 8'h01, 32'h0000_0100, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(0, "R_start", 2);
    wait_evt(1, "R_done", 6);
    check_eq("R_p1_rd_hold", p1_if.rdata, mem_fn(32'h0000_0800));

    // Repeat contention after port 0 was served: port 1 wins.
    step();
    ad_lat = 3;
    push_op(1, 8'h01, 32'h0000_0600, 32'h4444_0000, 4'h0, mem_fn(32'h0000_0600));
    push_op(0, 8'h01, 32'h0000_0500, 32'h3333_0000, 4'h0, mem_fn(32'h0000_0500));
    drive(0, 8'h01, 32'h0000_0500, 32'h3333_0000, 4'h0);
    drive(1, 8'h01, 32'h0000_0600, 32'h4444_0000, 4'h0);
    step();
    release_starts();
    wait_evt(0, "B_start1", 2);
    wait_evt(2, "B_done1", 4);
    wait_evt(0, "B_start0", 1);
    wait_evt(1, "B_done0", 4);

    // Write fields from port 1.
    step();
    ad_lat = 2;
    push_op(1, 8'h02, 32'h0003_FFFC, 32'hA5A5_5A5A, 4'b0011, mem_fn(32'h0003_FFFC));
    drive(1, 8'h02, 32'h0003_FFFC, 32'hA5A5_5A5A, 4'b0011);
    step();
    release_starts();
    wait_evt(0, "W_start", 2);
    wait_evt(2, "W_done", 3);
    check_eq("W_hold_addr", sram_if.addr, 32'h0003_FFFC);
    check_eq("W_hold_wdata", sram_if.wdata, 32'hA5A5_5A5A);

    // Timeout with a late done; next grant must wait for sram_busy=0.
    step();
    check_eq("T_err_before", {31'd0, timeout_err}, 32'd0);
    ad_lat = TO + 6;
    push_op(0, 8'h01, 32'h0000_0700, 32'h0, 4'h0, 32'hDEAD_BEEF);
    drive(0, 8'h01, 32'h0000_0700, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(0, "T_start", 2);
    wait_evt(1, "T_done", TO);
    check_eq("T_err_after", {31'd0, timeout_err}, 32'd1);
    ad_lat = 3;
    step();
    push_op(1, 8'h01, 32'h0000_0900, 32'h0, 4'h0, mem_fn(32'h0000_0900));
    drive(1, 8'h01, 32'h0000_0900, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(3, "T_late_done", 5);
    wait_evt(0, "T_start_after_busy", 1);
    wait_evt(2, "T_done_next", 4);

    // Protocol error: second start while busy is dropped.
    step();
    check_eq("P_err_before", {31'd0, proto_err}, 32'd0);
    ad_lat = 6;
    push_op(0, 8'h01, 32'h0000_0240, 32'h0, 4'h0, mem_fn(32'h0000_0240));
    drive(0, 8'h01, 32'h0000_0240, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(0, "P_start", 2);
    step();
    drive(0, 8'h01, 32'h0000_0999, 32'h0, 4'h0);
    step();
    release_starts();
    check_eq("P_err_after", {31'd0, proto_err}, 32'd1);
    wait_evt(1, "P_done", 6);
    check_eq("P_busy_after", {31'd0, p0_if.busy}, 32'd0);

    // Reset while in WAIT: outputs clear at once and no done follows.
    step();
    ad_lat = 20;
    exp_sram_q.push_back('{cmd: 8'h01, addr: 32'h0000_0A00, wdata: 32'h0, wstrb: 4'h0});
    drive(1, 8'h01, 32'h0000_0A00, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(0, "X_start", 2);
    step();
    step();
    resetn = 1'b0;
    #1;
    check_all_zero("X_rst");
    step();
    resetn = 1'b1;
    repeat (25) step();
    ad_lat = 2;
    push_op(0, 8'h01, 32'h0000_0B00, 32'h0, 4'h0, mem_fn(32'h0000_0B00));
    drive(0, 8'h01, 32'h0000_0B00, 32'h0, 4'h0);
    step();
    release_starts();
    wait_evt(0, "X_start_after", 2);
    wait_evt(1, "X_done_after", 3);

    repeat (3) step();
    check_eq("sb_empty", exp_sram_q.size() + exp_rd0_q.size() + exp_rd1_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
